// File: rtl/rld_fifo_write_arbiter.sv
// rld_fifo_write_arbiter: round-robin burst writer from per-queue ingress FIFOs to the RLDRAM write path.
// Latency: grant 1 cycle after eligibility; write word registered 1 cycle after its issue.
// Backpressure: mem_ready low holds the burst with no pop; an empty granted queue also stalls unless padding.
// Optional feature: define RLD_WR_PAD_EN to complete short packet-end bursts with zero pad words.
module rld_fifo_write_arbiter #(
  parameter int TDATA_WIDTH    = 32,
  parameter int NUM_QUEUES     = 4,
  parameter int QUEUE_ID_WIDTH = 2,
  parameter int BURST_LEN      = 4,
  localparam int W             = 8*TDATA_WIDTH+9
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_QUEUES*W-1:0]     din,
  input  logic [NUM_QUEUES-1:0]       din_empty,
  input  logic [NUM_QUEUES-1:0]       din_burst_ready,
  output logic [NUM_QUEUES-1:0]       din_rd_en,
  input  logic [NUM_QUEUES-1:0]       mem_queue_full,
  input  logic                        mem_ready,
  output logic [W-1:0]                dout,
  output logic                        dout_valid,
  output logic                        dout_pad,
  output logic [QUEUE_ID_WIDTH-1:0]   dout_queue_id,
  output logic                        burst_start,
  output logic [NUM_QUEUES-1:0]       burst_inc
);

  localparam int CNT_W = $clog2(BURST_LEN) + 1;

`ifdef RLD_WR_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif

  typedef enum logic {IDLE, BURST} state_t;

  state_t                      state_q, state_d;
  logic [QUEUE_ID_WIDTH-1:0]   grant_q, grant_d;
  logic [QUEUE_ID_WIDTH-1:0]   last_grant_q, last_grant_d;
  logic [CNT_W-1:0]            word_cnt_q, word_cnt_d;
  logic [W-1:0]                dout_q, dout_d;
  logic                        dout_valid_q, dout_valid_d;
  logic                        dout_pad_q, dout_pad_d;
  logic [QUEUE_ID_WIDTH-1:0]   dout_queue_id_q, dout_queue_id_d;
  logic                        burst_start_q, burst_start_d;
  logic [NUM_QUEUES-1:0]       burst_inc_q, burst_inc_d;

  logic [NUM_QUEUES-1:0]       eligible;
  logic [NUM_QUEUES-1:0]       grant_oh;
  logic [W-1:0]                head_word;
  logic                        head_avail;
  logic                        issue;
  logic                        last_word;
  logic                        found;

  // Queue index offset positions after base, wrapping at NUM_QUEUES.
  function automatic logic [QUEUE_ID_WIDTH-1:0] rr_idx(input logic [QUEUE_ID_WIDTH-1:0] base,
                                                       input int off);
    return QUEUE_ID_WIDTH'((int'(base) + off) % NUM_QUEUES);
  endfunction

  // Decode the granted queue and decide whether a word goes out this cycle.
  always_comb begin
    eligible   = din_burst_ready & ~din_empty & ~mem_queue_full;
    grant_oh   = '0;
    grant_oh[grant_q] = 1'b1;
    head_avail = ~din_empty[grant_q];
    head_word  = din[int'(grant_q)*W +: W];
    issue      = (state_q == BURST) && mem_ready && (head_avail || PAD_EN);
    last_word  = (word_cnt_q == CNT_W'(BURST_LEN-1));
  end

  // Pop only real words of the granted queue.
  assign din_rd_en = (issue && head_avail) ? grant_oh : '0;

  // Next-state: round-robin grant in IDLE, word issue and burst completion in BURST.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    word_cnt_d      = word_cnt_q;
    dout_d          = dout_q;
    dout_valid_d    = 1'b0;
    dout_pad_d      = 1'b0;
    dout_queue_id_d = dout_queue_id_q;
    burst_start_d   = 1'b0;
    burst_inc_d     = '0;
    found           = 1'b0;
    if (state_q == IDLE) begin
      for (int i = 1; i <= NUM_QUEUES; i++) begin
        if (!found && eligible[rr_idx(last_grant_q, i)]) begin
          found   = 1'b1;
          grant_d = rr_idx(last_grant_q, i);
        end
      end
      if (found) begin
        last_grant_d = grant_d;
        word_cnt_d   = '0;
        state_d      = BURST;
      end
    end else if (issue) begin
      dout_d          = head_avail ? head_word : '0;
      dout_valid_d    = 1'b1;
      dout_pad_d      = ~head_avail;
      dout_queue_id_d = grant_q;
      burst_start_d   = (word_cnt_q == '0);
      if (last_word) begin
        burst_inc_d = grant_oh;
        word_cnt_d  = '0;
        state_d     = IDLE;
      end else begin
        word_cnt_d = word_cnt_q + 1'b1;
      end
    end
  end

  // State and registered outputs; reset abandons any partial burst.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      grant_q         <= '0;
      last_grant_q    <= QUEUE_ID_WIDTH'(NUM_QUEUES-1);
      word_cnt_q      <= '0;
      dout_q          <= '0;
      dout_valid_q    <= 1'b0;
      dout_pad_q      <= 1'b0;
      dout_queue_id_q <= '0;
      burst_start_q   <= 1'b0;
      burst_inc_q     <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      word_cnt_q      <= word_cnt_d;
      dout_q          <= dout_d;
      dout_valid_q    <= dout_valid_d;
      dout_pad_q      <= dout_pad_d;
      dout_queue_id_q <= dout_queue_id_d;
      burst_start_q   <= burst_start_d;
      burst_inc_q     <= burst_inc_d;
    end
  end

  assign dout          = dout_q;
  assign dout_valid    = dout_valid_q;
  assign dout_pad      = PAD_EN ? dout_pad_q : 1'b0;
  assign dout_queue_id = dout_queue_id_q;
  assign burst_start   = burst_start_q;
  assign burst_inc     = burst_inc_q;

endmodule

// File: tb/tb_rld_fifo_write_arbiter.sv
// tb_rld_fifo_write_arbiter: directed vector table, hand sequences and a queue-based random reference
// model for the burst write arbiter. Covers reset, round-robin order, full-region skipping, stalls,
// short packet-end bursts (padded or stalled depending on RLD_WR_PAD_EN) and mid-burst reset.
`timescale 1ns/1ps
module tb_rld_fifo_write_arbiter;
  localparam int NQ = 4;
  localparam int QW = 2;
  localparam int BL = 4;
  localparam int W  = 8*32+9;
`ifdef RLD_WR_PAD_EN
  localparam bit PAD = 1'b1;
`else
  localparam bit PAD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset;
  logic [NQ*W-1:0] din;
  logic [NQ-1:0]   din_empty, din_burst_ready, din_rd_en, mem_queue_full, burst_inc;
  logic            mem_ready, dout_valid, dout_pad, burst_start;
  logic [W-1:0]    dout;
  logic [QW-1:0]   dout_queue_id;

  rld_fifo_write_arbiter #(.TDATA_WIDTH(32), .NUM_QUEUES(NQ), .QUEUE_ID_WIDTH(QW), .BURST_LEN(BL)) dut (
    .clk(clk), .reset(reset), .din(din), .din_empty(din_empty), .din_burst_ready(din_burst_ready),
    .din_rd_en(din_rd_en), .mem_queue_full(mem_queue_full), .mem_ready(mem_ready), .dout(dout),
    .dout_valid(dout_valid), .dout_pad(dout_pad), .dout_queue_id(dout_queue_id),
    .burst_start(burst_start), .burst_inc(burst_inc));

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [W-1:0] mkword(input int q, input int i);
    logic [W-1:0] w;
    w = '0;
    w[W-1 -: 8]  = 8'(q + 1);
    w[15:0]      = 16'(i);
    w[128 +: 8]  = 8'(i*7 + q);
    return w;
  endfunction

  function automatic logic [W-1:0] rndword();
    logic [W-1:0] w;
    w = '0;
    repeat (9) w = (w << 32) | W'($urandom);
    return w;
  endfunction

  // ---------------- ingress FIFO contents and reference model state ----------------
  logic [W-1:0] fq[NQ][$];
  bit           pkt_end[NQ];
  logic         mr_v;
  logic [NQ-1:0] full_v;
  bit           m_busy;
  int           m_g, m_cnt, m_last;
  int           obs_vld, obs_pad, obs_inc, cyc;
  int           st_q[$];
  int           st_cyc[$];
  int           rq;

  // One clock: present FIFO heads, predict pops/outputs from the arbitration rules, compare.
  task automatic step();
    logic [NQ-1:0] elig, e_rd, e_inc;
    logic          e_vld, e_pad, e_st, real_w;
    logic [W-1:0]  e_dat;
    int            e_id;
    @(negedge clk);
    for (int q = 0; q < NQ; q++) begin
      din[q*W +: W]      = (fq[q].size() > 0) ? fq[q][0] : '0;
      din_empty[q]       = (fq[q].size() == 0);
      din_burst_ready[q] = (fq[q].size() >= BL) || pkt_end[q];
    end
    mem_ready      = mr_v;
    mem_queue_full = full_v;
    #1;
    elig  = din_burst_ready & ~din_empty & ~mem_queue_full;
    e_rd  = '0; e_inc = '0; e_vld = 1'b0; e_pad = 1'b0; e_st = 1'b0; e_dat = '0; e_id = 0;
    if (!m_busy) begin
      for (int k = 1; k <= NQ; k++) begin
        if (!m_busy && elig[(m_last + k) % NQ]) begin
          m_busy = 1'b1;
          m_g    = (m_last + k) % NQ;
          m_last = m_g;
          m_cnt  = 0;
        end
      end
    end else if (mem_ready && (fq[m_g].size() > 0 || PAD)) begin
      real_w   = (fq[m_g].size() > 0);
      e_rd[m_g] = real_w;
      e_vld    = 1'b1;
      e_dat    = real_w ? fq[m_g][0] : '0;
      e_pad    = ~real_w;
      e_id     = m_g;
      e_st     = (m_cnt == 0);
      m_cnt++;
      if (m_cnt == BL) begin
        e_inc[m_g] = 1'b1;
        m_busy     = 1'b0;
      end
    end
    chk("din_rd_en", W'(din_rd_en), W'(e_rd));
    @(posedge clk);
    #1;
    cyc++;
    chk("dout_valid", W'(dout_valid), W'(e_vld));
    chk("burst_start", W'(burst_start), W'(e_st));
    chk("burst_inc", W'(burst_inc), W'(e_inc));
    chk("dout_pad", W'(dout_pad), W'(e_pad));
    if (e_vld) begin
      chk("dout", dout, e_dat);
      chk("dout_queue_id", W'(dout_queue_id), W'(e_id));
    end
    if (dout_valid) obs_vld++;
    if (dout_pad) obs_pad++;
    if (|burst_inc) obs_inc++;
    if (dout_valid && burst_start) begin
      st_q.push_back(int'(dout_queue_id));
      st_cyc.push_back(cyc);
    end
    if (|e_rd) begin
      void'(fq[m_g].pop_front());
      if (fq[m_g].size() == 0) pkt_end[m_g] = 1'b0;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    din = '0; din_empty = '1; din_burst_ready = '0; mem_queue_full = '0; mem_ready = 1'b0;
    for (int q = 0; q < NQ; q++) begin
      fq[q].delete();
      pkt_end[q] = 1'b0;
    end
    m_busy = 1'b0; m_last = NQ - 1; m_cnt = 0; m_g = 0;
    repeat (2) @(negedge clk);
    chk("rst_dout", dout, '0);
    chk("rst_dout_valid", W'(dout_valid), W'(0));
    chk("rst_dout_pad", W'(dout_pad), W'(0));
    chk("rst_queue_id", W'(dout_queue_id), W'(0));
    chk("rst_burst_start", W'(burst_start), W'(0));
    chk("rst_burst_inc", W'(burst_inc), W'(0));
    chk("rst_rd_en", W'(din_rd_en), W'(0));
    reset = 1'b0;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [NQ-1:0] emp, brdy, full;
    logic          mr;
    logic [NQ-1:0] rd;
    logic          vld, st;
    logic [NQ-1:0] inc;
    int            qid;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input logic [NQ-1:0] emp, brdy, full, input logic mr,
                              input logic [NQ-1:0] rd, input logic vld, st,
                              input logic [NQ-1:0] inc, input int qid);
    vec_t v;
    v.emp = emp; v.brdy = brdy; v.full = full; v.mr = mr;
    v.rd = rd; v.vld = vld; v.st = st; v.inc = inc; v.qid = qid;
    tbl.push_back(v);
  endfunction

  // One grant cycle followed by four back-to-back words from queue q.
  function automatic void add_burst(input logic [NQ-1:0] emp, brdy, full, input int q);
    add(emp, brdy, full, 1'b1, '0, 1'b0, 1'b0, '0, 0);
    for (int k = 0; k < BL; k++)
      add(emp, brdy, full, 1'b1, NQ'(1 << q), 1'b1, (k == 0), (k == BL-1) ? NQ'(1 << q) : '0, q);
  endfunction

  initial begin
    reset = 1'b1;
    din = '0; din_empty = '1; din_burst_ready = '0; mem_queue_full = '0; mem_ready = 1'b0;
    mr_v = 1'b1; full_v = '0; obs_vld = 0; obs_pad = 0; obs_inc = 0; cyc = 0;

    // Queue 2 alone eligible.
    add_burst(4'b1011, 4'b0100, 4'b0000, 2);
    add(4'b1111, 4'b0000, 4'b0000, 1'b1, '0, 1'b0, 1'b0, '0, 0);
    // Queue 1 region full: grants alternate 0,2,0,2.
    for (int b = 0; b < 4; b++) add_burst(4'b1000, 4'b0111, 4'b0010, (b % 2 == 0) ? 0 : 2);
    // Queue 3 with mem_ready low for three cycles after word 1.
    add(4'b0111, 4'b1000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 0);
    add(4'b0111, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b1, 4'b0000, 3);
    add(4'b0111, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000, 3);
    for (int s = 0; s < 3; s++) add(4'b0111, 4'b1000, 4'b0000, 1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 0);
    add(4'b0111, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b0000, 3);
    add(4'b0111, 4'b1000, 4'b0000, 1'b1, 4'b1000, 1'b1, 1'b0, 4'b1000, 3);
    add(4'b1111, 4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 4'b0000, 0);

    do_reset();
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      for (int q = 0; q < NQ; q++) din[q*W +: W] = mkword(q, i);
      din_empty = tbl[i].emp; din_burst_ready = tbl[i].brdy;
      mem_queue_full = tbl[i].full; mem_ready = tbl[i].mr;
      #1;
      chk($sformatf("tbl%0d_rd_en", i), W'(din_rd_en), W'(tbl[i].rd));
      @(posedge clk);
      #1;
      chk($sformatf("tbl%0d_valid", i), W'(dout_valid), W'(tbl[i].vld));
      chk($sformatf("tbl%0d_start", i), W'(burst_start), W'(tbl[i].st));
      chk($sformatf("tbl%0d_inc", i), W'(burst_inc), W'(tbl[i].inc));
      if (tbl[i].vld) begin
        chk($sformatf("tbl%0d_qid", i), W'(dout_queue_id), W'(tbl[i].qid));
        chk($sformatf("tbl%0d_dout", i), dout, mkword(tbl[i].qid, i));
      end
    end

    // All queues eligible: order 0,1,2,3,0 with one idle cycle between bursts.
    do_reset();
    for (int q = 0; q < NQ; q++) repeat (24) fq[q].push_back(rndword());
    mr_v = 1'b1; full_v = '0;
    st_q.delete(); st_cyc.delete();
    repeat (26) step();
    chk("rr_start_count", W'(st_q.size() >= 5), W'(1));
    for (int k = 0; k < 5; k++) begin
      if (k < st_q.size()) chk($sformatf("rr_order%0d", k), W'(st_q[k]), W'(k % NQ));
      if (k + 1 < st_cyc.size()) chk($sformatf("rr_gap%0d", k), W'(st_cyc[k+1] - st_cyc[k]), W'(BL + 1));
    end

    // Short packet-end burst on queue 0 (two words).
    do_reset();
    fq[0].push_back(rndword()); fq[0].push_back(rndword()); pkt_end[0] = 1'b1;
    mr_v = 1'b1; full_v = '0; obs_vld = 0; obs_pad = 0; obs_inc = 0;
`ifdef RLD_WR_PAD_EN
    repeat (7) step();
    chk("short_valid", W'(obs_vld), W'(4));
    chk("short_pad", W'(obs_pad), W'(2));
    chk("short_inc", W'(obs_inc), W'(1));
`else
    repeat (8) step();
    chk("short_stall_valid", W'(obs_vld), W'(2));
    chk("short_stall_inc", W'(obs_inc), W'(0));
    fq[0].push_back(rndword()); fq[0].push_back(rndword());
    repeat (5) step();
    chk("short_valid", W'(obs_vld), W'(4));
    chk("short_pad", W'(obs_pad), W'(0));
    chk("short_inc", W'(obs_inc), W'(1));
`endif

    // Reset after word 2 of a queue-1 burst.
    do_reset();
    repeat (8) fq[1].push_back(rndword());
    mr_v = 1'b1; full_v = '0;
    repeat (4) step();
    @(negedge clk);
    reset = 1'b1;
    din_empty = '1; din_burst_ready = '0;
    #1;
    chk("midrst_valid", W'(dout_valid), W'(0));
    chk("midrst_dout", dout, '0);
    chk("midrst_qid", W'(dout_queue_id), W'(0));
    chk("midrst_start", W'(burst_start), W'(0));
    chk("midrst_inc", W'(burst_inc), W'(0));
    chk("midrst_rd_en", W'(din_rd_en), W'(0));
    m_busy = 1'b0; m_last = NQ - 1; m_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int q = 0; q < NQ; q++) if (q != 1) repeat (4) fq[q].push_back(rndword());
    st_q.delete(); st_cyc.delete();
    repeat (6) step();
    chk("midrst_next_grant", W'((st_q.size() > 0) ? st_q[0] : 9), W'(0));

    // Randomized traffic against the reference model.
    do_reset();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 1) == 1) begin
        rq = $urandom_range(0, NQ-1);
        if (fq[rq].size() < 12) fq[rq].push_back(rndword());
      end
      if ($urandom_range(0, 19) == 0) begin
        rq = $urandom_range(0, NQ-1);
        if (fq[rq].size() > 0) pkt_end[rq] = 1'b1;
      end
      mr_v   = ($urandom_range(0, 3) != 0);
      full_v = ($urandom_range(0, 3) == 0) ? NQ'($urandom) : '0;
      step();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
